// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcode/funct constants and ALU control codes for mc_ctrl.
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;
  typedef enum logic [1:0] {ALU_NONE, ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LD    = 6'h37;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SD    = 6'h3F;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_DADDI = 6'h18;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_DADD   = 6'h2C;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_DSUB   = 6'h2E;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [2:0] AC_ADD   = 3'b010;
  localparam logic [2:0] AC_SUB   = 3'b110;
  localparam logic [2:0] AC_AND   = 3'b000;
  localparam logic [2:0] AC_OR    = 3'b001;
  localparam logic [2:0] AC_SLT   = 3'b111;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps ALU-op class and funct to alucontrol; flags funct values with no ALU meaning.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        bad_funct
);
  logic [2:0] fc;
  always_comb begin
    fc = AC_ADD;
    bad_funct = 1'b0;
    case (funct)
      F_ADD, F_DADD: fc = AC_ADD;
      F_SUB, F_DSUB: fc = AC_SUB;
      F_AND:         fc = AC_AND;
      F_OR:          fc = AC_OR;
      F_SLT:         fc = AC_SLT;
      default:       bad_funct = 1'b1;
    endcase
    alucontrol = aluop == ALU_ADD ? AC_ADD :
                 aluop == ALU_SUB ? AC_SUB :
                 aluop == ALU_FUNCT ? fc : 3'b000;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle Moore control FSM with memory handshake, halt, illegal-op pulse and retire counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             instr_nop,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);
  state_t st, nxt, dec_nxt;
  aluop_t aluop;
  logic bad_funct, is_mem, is_load, pcwrite, branch, retire;
  mc_aludec u_aludec (.aluop(aluop), .funct(funct), .alucontrol(alucontrol), .bad_funct(bad_funct));
  assign is_load = op == OP_LW || op == OP_LD;
  assign is_mem  = is_load || op == OP_SW || op == OP_SD;
  assign dec_nxt = instr_nop ? HALT :
                   is_mem ? MEMADR :
                   (op == OP_RTYPE && !bad_funct) ? EXECUTE :
                   op == OP_BEQ ? BRANCH :
                   (op == OP_ADDI || op == OP_DADDI) ? ADDIEX :
                   op == OP_J ? JUMP : FETCH;
  always_comb begin
    nxt = st;
    case (st)
      FETCH:                              nxt = mem_ready ? DECODE : FETCH;
      DECODE:                             nxt = dec_nxt;
      MEMADR:                             nxt = is_load ? MEMRD : MEMWR;
      MEMRD:                              nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:                              nxt = mem_ready ? FETCH : MEMWR;
      EXECUTE:                            nxt = ALUWB;
      ADDIEX:                             nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      HALT:                               nxt = HALT;
      default:                            nxt = FETCH;
    endcase
  end
  // Only completed instructions retire; the DECODE->FETCH illegal path is excluded.
  assign retire = nxt == FETCH && st inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP};
  always_comb begin
    mem_req = 1'b0;
    memwrite = 1'b0;
    iord = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    branch = 1'b0;
    regwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop = ALU_NONE;
    case (st)
      FETCH:   begin mem_req = 1'b1; alusrcb = 2'b01; aluop = ALU_ADD; irwrite = mem_ready; pcwrite = mem_ready; end
      DECODE:  begin alusrcb = 2'b11; aluop = ALU_ADD; end
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; aluop = ALU_ADD; end
      MEMRD:   begin mem_req = 1'b1; iord = 1'b1; end
      MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      MEMWR:   begin mem_req = 1'b1; iord = 1'b1; memwrite = 1'b1; end
      EXECUTE: begin alusrca = 1'b1; aluop = ALU_FUNCT; end
      ALUWB:   begin regwrite = 1'b1; regdst = 1'b1; end
      BRANCH:  begin alusrca = 1'b1; aluop = ALU_SUB; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; aluop = ALU_ADD; end
      ADDIWB:  regwrite = 1'b1;
      JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end
  assign pcen   = pcwrite | (branch & zero);
  assign halted = st == HALT;
  assign state  = st;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= FETCH;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      st <= nxt;
      illegal <= st == DECODE && nxt == FETCH;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl (CNT_W=4 to exercise counter wrap).
module tb_mc_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic instr_nop = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca, pcen, halted, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state, instret;
  int checks = 0, errors = 0;
  mc_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .instr_nop(instr_nop), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .halted(halted), .illegal(illegal),
    .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic illegal_run(input string tag, input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    chk({tag, "_fetch"}, state, 0);
    step();
    chk({tag, "_decode"}, state, 1);
    step();
    chk({tag, "_pulse"}, illegal, 1);
    chk({tag, "_back"}, state, 0);
    chk({tag, "_noret"}, instret, 5);
    mem_ready = 1'b0;
    step();
    chk({tag, "_pulse_end"}, illegal, 0);
    mem_ready = 1'b1;
  endtask
  initial begin
    int lw_seq[6];
    lw_seq = '{0, 1, 2, 3, 4, 0};
    #12;
    chk("rst_state", state, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_memreq", mem_req, 1);
    chk("first_irwrite", irwrite, 1);
    op = 6'h23;
    for (int i = 0; i < 6; i++) begin
      chk("lw_state", state, lw_seq[i]);
      chk("lw_regwrite", regwrite, lw_seq[i] == 4);
      chk("lw_memtoreg", memtoreg, lw_seq[i] == 4);
      if (i < 5) step();
    end
    chk("lw_instret", instret, 1);
    op = 6'h2B;
    step();
    step();
    step();
    chk("sw_state", state, 5);
    for (int i = 0; i < 4; i++) begin
      mem_ready = i == 3;
      chk("sw_memwrite", memwrite, 1);
      chk("sw_hold", state, 5);
      step();
    end
    mem_ready = 1'b1;
    chk("sw_done", state, 0);
    chk("sw_instret", instret, 2);
    op = 6'h04;
    zero = 1'b1;
    step();
    step();
    chk("beq1_state", state, 8);
    chk("beq1_pcen", pcen, 1);
    chk("beq1_alu", alucontrol, 3'b110);
    chk("beq1_pcsrc", pcsrc, 1);
    step();
    chk("beq1_fetch", state, 0);
    zero = 1'b0;
    step();
    step();
    chk("beq0_pcen", pcen, 0);
    step();
    chk("beq0_instret", instret, 4);
    op = 6'h00;
    funct = 6'h2A;
    step();
    step();
    chk("slt_state", state, 6);
    chk("slt_alu", alucontrol, 3'b111);
    step();
    chk("aluwb_regdst", regdst, 1);
    chk("aluwb_regwrite", regwrite, 1);
    step();
    chk("rtype_instret", instret, 5);
    illegal_run("badfunct", 6'h00, 6'h3F);
    illegal_run("badop", 6'h3E, 6'h20);
    do_reset();
    op = 6'h02;
    for (int i = 0; i < 17; i++) begin
      step();
      step();
      if (i == 0) begin
        chk("j_state", state, 11);
        chk("j_pcen", pcen, 1);
        chk("j_pcsrc", pcsrc, 2);
      end
      step();
    end
    chk("j_wrap", instret, 1);
    op = 6'h23;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("memrd_wait", state, 3);
    chk("memrd_iord", iord, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_instret", instret, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    op = 6'h00;
    instr_nop = 1'b1;
    step();
    step();
    for (int i = 0; i < 50; i++) begin
      if (i == 0 || i == 49) begin
        chk("halt_state", state, 12);
        chk("halt_flag", halted, 1);
        chk("halt_memreq", mem_req, 0);
      end
      step();
    end
    instr_nop = 1'b0;
    do_reset();
    #1;
    chk("halt_exit", state, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
